// File: rtl/lift_call_scheduler_if.sv
// rtl/lift_call_scheduler_if.sv - call, dispatch and status signals of the hall-call scheduler
// master = call buttons plus lift FSM side, slave = scheduler.
interface lift_call_scheduler_if;
  logic       call_vld;
  logic [2:0] call_code;
  logic [1:0] cur_floor;
  logic       req_rdy;
  logic       done;
  logic       req_vld;
  logic [2:0] req_code;
  logic       dir;
  logic [5:0] pending;
  logic       busy;
  logic       timeout_err;

  modport master (
    output call_vld, call_code, cur_floor, req_rdy, done,
    input  req_vld, req_code, dir, pending, busy, timeout_err
  );

  modport slave (
    input  call_vld, call_code, cur_floor, req_rdy, done,
    output req_vld, req_code, dir, pending, busy, timeout_err
  );
endinterface

// File: rtl/lift_call_scheduler.sv
// rtl/lift_call_scheduler.sv - SCAN hall-call scheduler for the four-floor lift
// Latches calls into a pending bitmap, dispatches one at a time, watchdogs the lift FSM.
module lift_call_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  lift_call_scheduler_if.slave if_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_REQ  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_pending;
  logic [5:0]  w_set;
  logic [5:0]  w_clr;
  logic [2:0]  r_req_code;
  logic        r_dir;
  logic        r_req_vld;
  logic        r_busy;
  logic        r_timeout_err;
  logic [15:0] r_wd_cnt;
  logic [2:0]  w_pick_idx;
  logic [2:0]  w_pick_code;
  logic        w_done_wait;
  logic        w_wd_expire;

  function automatic logic [5:0] f_code_mask(input logic [2:0] code);
    logic [5:0] mask;
    case (code)
      3'b001:  mask = 6'b000001;
      3'b010:  mask = 6'b000010;
      3'b011:  mask = 6'b000100;
      3'b110:  mask = 6'b001000;
      3'b111:  mask = 6'b010000;
      3'b100:  mask = 6'b100000;
      default: mask = 6'b000000;
    endcase
    f_code_mask = mask;
  endfunction

  function automatic logic [2:0] f_idx_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b001;
      3'd1:    code = 3'b010;
      3'd2:    code = 3'b011;
      3'd3:    code = 3'b110;
      3'd4:    code = 3'b111;
      3'd5:    code = 3'b100;
      default: code = 3'b000;
    endcase
    f_idx_code = code;
  endfunction

  // Walks the sweep priority list from lowest to highest so the last hit wins.
  // Bits 0..2 are up calls at floor b; bits 3..5 are down calls at floor b-2.
  function automatic logic [2:0] f_pick(input logic [5:0] pend, input logic [1:0] floor,
                                        input logic dir_down);
    logic [2:0] pick;
    pick = 3'd0;
    if (!dir_down) begin
      for (int b = 2; b >= 0; b--) if (pend[b] && (b < int'(floor))) pick = 3'(b);
      for (int b = 3; b <= 5; b++) if (pend[b]) pick = 3'(b);
      for (int b = 2; b >= 0; b--) if (pend[b] && (b >= int'(floor))) pick = 3'(b);
    end else begin
      for (int b = 3; b <= 5; b++) if (pend[b] && ((b - 2) > int'(floor))) pick = 3'(b);
      for (int b = 2; b >= 0; b--) if (pend[b]) pick = 3'(b);
      for (int b = 3; b <= 5; b++) if (pend[b] && ((b - 2) <= int'(floor))) pick = 3'(b);
    end
    f_pick = pick;
  endfunction

  always_comb begin
    w_set       = 6'b000000;
    w_clr       = 6'b000000;
    w_done_wait = (r_state == ST_WAIT) && if_bus.done;
    w_wd_expire = (r_state == ST_WAIT) && !if_bus.done && (r_wd_cnt == LP_WD_LAST);
    w_pick_idx  = f_pick(r_pending, if_bus.cur_floor, r_dir);
    w_pick_code = f_idx_code(w_pick_idx);
    if (if_bus.call_vld) w_set = f_code_mask(if_bus.call_code);
    if (w_done_wait)     w_clr = f_code_mask(r_req_code);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (r_pending != 6'b000000) w_state_nxt = ST_SEL;
      ST_SEL:  w_state_nxt = ST_REQ;
      ST_REQ:  if (if_bus.req_rdy) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_done_wait || w_wd_expire) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A set on the bit being cleared wins, so a re-press during service is not lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending     <= 6'b000000;
      r_req_code    <= 3'b000;
      r_dir         <= 1'b0;
      r_req_vld     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd_cnt      <= 16'd0;
    end else begin
      r_pending     <= (r_pending & ~w_clr) | w_set;
      r_req_vld     <= (w_state_nxt == ST_REQ);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_timeout_err <= w_wd_expire;
      if (r_state == ST_SEL) begin
        r_req_code <= w_pick_code;
        r_dir      <= w_pick_code[2];
      end
      if (r_state == ST_WAIT) begin
        r_wd_cnt <= r_wd_cnt + 16'd1;
      end else begin
        r_wd_cnt <= 16'd0;
      end
    end
  end

  assign if_bus.req_vld     = r_req_vld;
  assign if_bus.req_code    = r_req_code;
  assign if_bus.dir         = r_dir;
  assign if_bus.pending     = r_pending;
  assign if_bus.busy        = r_busy;
  assign if_bus.timeout_err = r_timeout_err;

endmodule

// File: doc/lift_call_scheduler.md
# lift_call_scheduler

Hall-call scheduler that sits between the six floor call buttons and the lift FSM in the four-floor elevator design. It latches call codes into a pending bitmap and chooses one call at a time using a directional sweep (SCAN) policy. It hands the chosen call to the lift FSM over a valid/ready handshake and clears the call only when the FSM reports the call served. A watchdog abandons a dispatch the FSM never completes.

## Interface
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before the dispatch is abandoned. Range 1..65535; the counter is 16 bits.
- clk  input  1  rising-edge clock. Single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- call_vld  input  1  call_code is valid this cycle.
- call_code  input  3  call code: 001=1U, 010=2U, 011=3U, 110=2D, 111=3D, 100=4D. Codes 000 and 101 are ignored.
- cur_floor  input  2  current lift floor, 0..3 for floors 1..4.
- req_rdy  input  1  lift FSM accepts req_code.
- done  input  1  one-cycle pulse: dispatched call has been served.
- req_vld  output  1  dispatch request valid.
- req_code  output  3  dispatched call code.
- dir  output  1  sweep direction, 0=UP, 1=DOWN.
- pending  output  6  pending bitmap: [0]=1U, [1]=2U, [2]=3U, [3]=2D, [4]=3D, [5]=4D.
- busy  output  1  high in SEL, REQ and WAIT.
- timeout_err  output  1  one-cycle pulse on watchdog expiry.

## Operation
- Call floor of each code: 1U=0, 2U=1, 3U=2, 2D=1, 3D=2, 4D=3. "Up calls" are 1U, 2U, 3U. "Down calls" are 2D, 3D, 4D.
- Capture: on a valid call_vld, the mapped pending bit is set. Re-pressing a pending call has no further effect.
- States:
  - IDLE: go to SEL when pending != 0.
  - SEL: one cycle. Choose the call, register req_code, update dir, go to REQ.
  - REQ: req_vld=1. When req_rdy=1, go to WAIT.
  - WAIT: on done, clear the req_code bit and go to IDLE. On watchdog expiry, go to IDLE; the bit stays set.
- SCAN selection. cur_floor is sampled in SEL. The first pending call in the priority list below wins.
  - dir=UP:
    1. Up calls with floor >= cur_floor, ascending floor.
    2. Down calls in the order 4D, 3D, 2D.
    3. Up calls with floor < cur_floor, ascending floor.
  - dir=DOWN:
    1. Down calls with floor <= cur_floor, descending floor.
    2. Up calls in the order 1U, 2U, 3U.
    3. Down calls with floor > cur_floor, descending floor.
  - New dir = code bit[2] of the chosen call (U gives UP, D gives DOWN).
- req_code and dir are held stable from SEL exit until the next SEL.
- Simultaneous events:
  - call_vld and done on different bits: both take effect.
  - call_vld and done on the same bit: the set wins and the bit stays 1.
- Ignored inputs:
  - done outside WAIT.
  - req_rdy outside REQ.
  - Invalid codes never change state.
- A call selected in SEL at the lift's current floor is still dispatched.

## Timing
- Reset values: state=IDLE, pending=0, req_vld=0, req_code=000, dir=0 (UP), busy=0, timeout_err=0, watchdog counter=0.
- An asynchronous reset mid-dispatch drops req_vld immediately and discards all pending calls.
- Call latency:
  - call_vld sampled at edge E0 sets pending after E0.
  - SEL is entered at E1.
  - req_vld=1 after E2.
- Handshake:
  - Transfer occurs at an edge where req_vld=1 and req_rdy=1. WAIT starts after that edge.
  - req_rdy may be held high; the minimum REQ duration is 1 cycle.
- Clearing the bit:
  - done sampled in WAIT at edge Ed clears the bit after Ed; IDLE is entered after Ed.
  - If other bits are pending, SEL follows at Ed+1.
- Watchdog:
  - The counter resets to 0 on entering WAIT and increments each WAIT cycle.
  - At count == TIMEOUT_CYCLES-1 with no done, timeout_err=1 for exactly the next cycle and the state goes to IDLE.
  - done arriving on the expiry cycle takes priority: normal clear, no error.
- busy is registered and is high exactly when state is SEL, REQ or WAIT.

## Test plan
- Reset and single call: release rst_n, then 1U at cur_floor=0 → pending=000001. After 2 edges, req_vld=1, req_code=001, dir=0. req_rdy then done → pending=0, state IDLE, busy=0.
- Sweep order: dir=UP, cur_floor=1, pending = 1U+3U+2D.
  - First dispatch 3U (dir=0). Done with cur_floor=2.
  - Next 2D (dir=1). Done with cur_floor=1.
  - Next 1U (dir=0).
- Handshake stall: hold req_rdy=0 for 10 cycles → req_vld and req_code stable throughout, no transfer. Then assert req_rdy → WAIT.
- Same-cycle set and clear: in WAIT for 4D, assert done and call 4D together → pending[5] stays 1 and 4D is redispatched.
- Watchdog: TIMEOUT_CYCLES=8, no done after transfer → timeout_err pulses after 8 WAIT cycles, bit retained, redispatch follows. Repeat with done on the 8th cycle → no timeout_err.
- Invalid codes and async reset: codes 000 and 101 leave pending unchanged. Assert rst_n=0 mid-REQ → req_vld=0 immediately, all outputs at reset values.
